// File: rtl/snake_pkg.sv
// Shared types and constants for the snake overlay: direction codes, FSM
// states, grid segment coordinates and the overlay colours.
package snake_pkg;

    typedef enum logic [1:0] {
        DIR_RIGHT = 2'b00,
        DIR_DOWN  = 2'b01,
        DIR_LEFT  = 2'b10,
        DIR_UP    = 2'b11
    } dir_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        INIT = 2'd1,
        RUN  = 2'd2,
        DEAD = 2'd3
    } state_e;

    typedef struct packed {
        logic [5:0] x;
        logic [5:0] y;
    } seg_t;

    typedef struct packed {
        logic [11:0] hc;
        logic [11:0] vc;
        logic        hs;
        logic        vs;
        logic        hb;
        logic        vb;
    } tim_t;

    localparam logic [11:0] SNAKE_HEAD_RGB = 12'hF00;
    localparam logic [11:0] SNAKE_BODY_RGB = 12'h0F0;
    localparam logic [11:0] SNAKE_DEAD_RGB = 12'h888;

endpackage

// File: rtl/snake_next_head.sv
// Combinational next-head: filters a reversing direction request, then steps
// the head one cell with toroidal wrap at the grid edges.
module snake_next_head
    import snake_pkg::*;
#(
    parameter int GRID_W = 50,
    parameter int GRID_H = 37
) (
    input  seg_t       head_i,
    input  logic [1:0] cur_dir_i,
    input  logic [1:0] req_dir_i,
    output logic [1:0] dir_o,
    output seg_t       head_o
);

    always_comb begin
        dir_o  = (req_dir_i == (cur_dir_i ^ 2'b10)) ? cur_dir_i : req_dir_i;
        head_o = head_i;
        case (dir_o)
            DIR_RIGHT: head_o.x = (head_i.x == 6'(GRID_W - 1)) ? 6'd0 : head_i.x + 6'd1;
            DIR_LEFT:  head_o.x = (head_i.x == 6'd0) ? 6'(GRID_W - 1) : head_i.x - 6'd1;
            DIR_DOWN:  head_o.y = (head_i.y == 6'(GRID_H - 1)) ? 6'd0 : head_i.y + 6'd1;
            DIR_UP:    head_o.y = (head_i.y == 6'd0) ? 6'(GRID_H - 1) : head_i.y - 6'd1;
            default:   head_o = head_i;
        endcase
    end

endmodule

// File: rtl/draw_snake.sv
// Snake overlay stage: 2-cycle draw pipeline over the background stream plus
// the movement FSM, which only updates segments right after a vblank rise.
module draw_snake
    import snake_pkg::*;
#(
    parameter int          CELL_LOG2 = 4,
    parameter int          GRID_W    = 50,
    parameter int          GRID_H    = 37,
    parameter int          MAX_LEN   = 32,
    parameter int          INIT_LEN  = 3,
    parameter int          MOVE_DIV  = 8,
    parameter logic [11:0] HEAD_RGB  = SNAKE_HEAD_RGB,
    parameter logic [11:0] BODY_RGB  = SNAKE_BODY_RGB,
    parameter logic [11:0] DEAD_RGB  = SNAKE_DEAD_RGB
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic [11:0] hcount_in,
    input  logic [11:0] vcount_in,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        hblnk_in,
    input  logic        vblnk_in,
    input  logic [11:0] rgb_in,
    input  logic [1:0]  dir_in,
    input  logic        grow,
    input  logic        start,
    output logic [11:0] hcount_out,
    output logic [11:0] vcount_out,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic        hblnk_out,
    output logic        vblnk_out,
    output logic [11:0] rgb_out,
    output logic [5:0]  len_out,
    output logic        dead
);

    localparam int CW = 12 - CELL_LOG2;
    localparam int DW = $clog2(MOVE_DIV + 1);

    state_e        state_q, state_d;
    seg_t          seg_q [MAX_LEN];
    seg_t          seg_d [MAX_LEN];
    logic [5:0]    len_q, len_d;
    logic [DW-1:0] div_q, div_d;
    logic          gp_q, gp_d;
    logic [1:0]    dir_q, dir_d;
    logic          vb_prev_q;

    tim_t          tim1_q, tim2_q;
    logic [11:0]   rgb1_q, rgb2_q, rgb_d;
    logic          hit_head_q, hit_body_q, hit_head_d, hit_body_d;

    logic [CW-1:0] cx, cy;
    logic          in_grid, tick, step, growing, collide;
    logic [1:0]    nd;
    seg_t          nh;

    // ---------------- draw pipeline ----------------
    assign cx      = hcount_in[11:CELL_LOG2];
    assign cy      = vcount_in[11:CELL_LOG2];
    assign in_grid = (cx < CW'(GRID_W)) && (cy < CW'(GRID_H));

    always_comb begin
        hit_head_d = 1'b0;
        hit_body_d = 1'b0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if (in_grid && (6'(i) < len_q) &&
                cx == CW'(seg_q[i].x) && cy == CW'(seg_q[i].y)) begin
                if (i == 0) hit_head_d = 1'b1;
                else        hit_body_d = 1'b1;
            end
        end
    end

    always_comb begin
        rgb_d = rgb1_q;
        if (hit_head_q || hit_body_q)
            rgb_d = (state_q == DEAD) ? DEAD_RGB : (hit_head_q ? HEAD_RGB : BODY_RGB);
        if (tim1_q.hb || tim1_q.vb)
            rgb_d = 12'h000;
    end

    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            tim1_q     <= '0;
            tim2_q     <= '0;
            rgb1_q     <= '0;
            rgb2_q     <= '0;
            hit_head_q <= 1'b0;
            hit_body_q <= 1'b0;
        end else begin
            tim1_q     <= '{hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in};
            tim2_q     <= tim1_q;
            rgb1_q     <= rgb_in;
            rgb2_q     <= rgb_d;
            hit_head_q <= hit_head_d;
            hit_body_q <= hit_body_d;
        end
    end

    assign {hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out} = tim2_q;
    assign rgb_out = rgb2_q;
    assign len_out = len_q;
    assign dead    = (state_q == DEAD);

    // ---------------- movement ----------------
    snake_next_head #(.GRID_W(GRID_W), .GRID_H(GRID_H)) u_next_head (
        .head_i    (seg_q[0]),
        .cur_dir_i (dir_q),
        .req_dir_i (dir_in),
        .dir_o     (nd),
        .head_o    (nh)
    );

    assign tick    = vblnk_in & ~vb_prev_q;
    assign step    = tick && (div_q == DW'(MOVE_DIV - 1));
    assign growing = (gp_q | grow) && (len_q < 6'(MAX_LEN));

    // The tail cell is vacated during a non-growing step, so it cannot kill.
    always_comb begin
        collide = 1'b0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if ((6'(i) < len_q) && !((6'(i) == len_q - 6'd1) && !growing) && seg_q[i] == nh)
                collide = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        seg_d   = seg_q;
        len_d   = len_q;
        div_d   = div_q;
        gp_d    = gp_q;
        dir_d   = dir_q;
        case (state_q)
            IDLE: if (start) state_d = INIT;
            INIT: begin
                for (int i = 0; i < INIT_LEN; i++)
                    seg_d[i] = '{x: 6'(GRID_W / 2 - i), y: 6'(GRID_H / 2)};
                len_d   = 6'(INIT_LEN);
                dir_d   = DIR_RIGHT;
                div_d   = '0;
                gp_d    = 1'b0;
                state_d = RUN;
            end
            RUN: begin
                if (start) begin
                    state_d = INIT;
                end else if (step) begin
                    div_d = '0;
                    dir_d = nd;
                    if (collide) begin
                        state_d = DEAD;
                    end else begin
                        for (int i = 1; i < MAX_LEN; i++) seg_d[i] = seg_q[i-1];
                        seg_d[0] = nh;
                        if (growing) len_d = len_q + 6'd1;
                        gp_d = 1'b0;
                    end
                end else begin
                    if (tick) div_d = div_q + DW'(1);
                    if (grow) gp_d = 1'b1;
                end
            end
            DEAD: if (start) state_d = INIT;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            for (int i = 0; i < MAX_LEN; i++) seg_q[i] <= '0;
            len_q     <= '0;
            div_q     <= '0;
            gp_q      <= 1'b0;
            dir_q     <= DIR_RIGHT;
            vb_prev_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            seg_q     <= seg_d;
            len_q     <= len_d;
            div_q     <= div_d;
            gp_q      <= gp_d;
            dir_q     <= dir_d;
            vb_prev_q <= vblnk_in;
        end
    end

endmodule

// File: doc/draw_snake.md
Name: draw_snake

Overview:
- Pipeline stage directly downstream of the background stage. Consumes its timing bus (hcount/vcount/sync/blank) and background rgb.
- Overlays a grid-based snake, with head and body drawn in distinct colours.
- Emits the timing bus delayed to stay aligned with the new rgb.
- Owns the snake movement state machine, which advances once per N frames during vertical blank, so the picture never tears.

Parameters:
- CELL_LOG2, 4: cell size is 2^CELL_LOG2 pixels (16).
- GRID_W, 50: grid columns (800 px / 16).
- GRID_H, 37: grid rows (600 px / 16, integer part).
- MAX_LEN, 32: segment buffer depth.
- INIT_LEN, 3: length after start.
- MOVE_DIV, 8: frames per move step.
- HEAD_RGB, 12'hF00: head colour.
- BODY_RGB, 12'h0F0: body colour.
- DEAD_RGB, 12'h888: whole-snake colour in DEAD.

Ports:
- pclk  in  1  pixel clock.
- rst  in  1  asynchronous, active-low reset.
- hcount_in, vcount_in  in  12 each  pixel position.
- hsync_in, vsync_in, hblnk_in, vblnk_in  in  1 each  timing.
- rgb_in  in  12  background colour.
- dir_in  in  2  requested direction: 00 right, 01 down, 10 left, 11 up.
- grow  in  1  one-cycle pulse: grow by one segment on the next move.
- start  in  1  one-cycle pulse: (re)initialise and run.
- hcount_out, vcount_out  out  12 each  timing delayed by 2 cycles.
- hsync_out, vsync_out, hblnk_out, vblnk_out  out  1 each  timing delayed by 2 cycles.
- rgb_out  out  12  composited colour.
- len_out  out  6  current length.
- dead  out  1  high in DEAD.

Behaviour:
- Reset (rst low, asynchronous): all outputs 0; state IDLE; len 0; frame divider 0; grow_pend 0; cur_dir 00.
- Draw pipeline, latency exactly 2 pclk for every output:
  - S1: cell_x = hcount_in >> CELL_LOG2, cell_y = vcount_in >> CELL_LOG2. Compare in parallel against segments 0..len-1; register hit_head (segment 0) and hit_body.
  - S2: select rgb_out:
    - DEAD: DEAD_RGB on any hit.
    - Otherwise: HEAD_RGB on hit_head, BODY_RGB on hit_body.
    - Blanking (hblnk or vblnk at S2): 12'h000.
    - No hit: delayed rgb_in.
  - Cells with cell_x >= GRID_W or cell_y >= GRID_H never hit.
- Frame tick: rising edge of vblnk_in (registered previous value). The divider counts ticks 0..MOVE_DIV-1; a step fires when it wraps.
- States:
  - IDLE: nothing drawn, len 0. start -> INIT.
  - INIT (1 cycle): seg[0]=(GRID_W/2, GRID_H/2); seg[i]=(x0-i, y0) for i<INIT_LEN; len=INIT_LEN; cur_dir=00; divider 0; grow_pend 0. -> RUN.
  - RUN: on step, compute the new head from cur_dir (after direction update), check collision, then shift or die. start -> INIT.
  - DEAD: snake frozen, dead=1. start -> INIT.
- Direction update, applied at each step:
  - dir_in replaces cur_dir unless dir_in == cur_dir ^ 2'b10 (reversal), which is ignored.
  - Only the value sampled at the step matters.
- Wrap-around:
  - x=GRID_W-1 moving right -> 0; x=0 moving left -> GRID_W-1.
  - Same for y with GRID_H.
- Collision: the new head equals any seg[0..len-1], excluding seg[len-1] when the snake is not growing this step (the tail vacates). On collision -> DEAD, with no shift.
- Shift: seg[i] <= seg[i-1], seg[0] <= new head. If grow_pend and len<MAX_LEN: len+1 and grow_pend cleared. At MAX_LEN the grow is dropped, and grow_pend is still cleared.
- grow: sets grow_pend in RUN; ignored in IDLE and DEAD.
- Simultaneous events:
  - A grow pulse on the same cycle as a step applies to that step.
  - start has priority over step.
- Segment state changes only in the cycle after a vblnk rise or in INIT; drawing always reads stable state.

Decomposition:
- Package snake_pkg holds:
  - direction codes (DIR_RIGHT/DOWN/LEFT/UP);
  - state encoding (IDLE, INIT, RUN, DEAD);
  - the segment typedef {x[5:0], y[5:0]};
  - the colour constants.
- One sub-module, snake_next_head: combinational next-head calculation with wrap and reversal filter. It is reusable by a future food/AI block.

Test Plan:
- Reset, then start, then a frame with pixel (400,288) -> rgb_out=12'hF00 two cycles later. Pixels (384,288) and (368,288) -> 12'h0F0. Pixel (352,288) -> rgb_in passthrough. len_out=3.
- dir_in=10 (reversal) held for 8 frames -> head moves right to (26,18), not left. With dir_in=01 -> next step head (26,19).
- Head at (49,18), dir right, one step -> head (0,18), no DEAD.
- grow pulse, then one step -> len_out=4 and the tail is unmoved. 29 further grows at 32 -> len_out saturates at 32.
- Length-5 snake steered down, left, up into its body -> dead=1 and all snake pixels 12'h888. Steering into the vacating tail cell -> no death. start -> len_out=3, dead=0.
- All timing outputs equal the inputs delayed by exactly 2 cycles. rst pulled low mid-frame -> all outputs 0 immediately and state IDLE.
